sram_arb: RTL and testbench
===========================

SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter: DEPTH, default 4, maximum number of outstanding accepted-but-unanswered requests.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: resetn  in  1  asynchronous, active-low reset.
REQ-004 Ports (inst master, prefix i_): i_req in 1, i_wr in 1, i_size in 2, i_wstrb in 4, i_addr in 32, i_wdata in 32, i_addr_ok out 1, i_data_ok out 1, i_rdata out 32; SRAM-like request/answer channel from fetch.
REQ-005 Ports (data master, prefix d_): same set and widths as REQ-004; SRAM-like channel from exe stage.
REQ-006 Ports (slave, prefix s_): s_req out 1, s_wr out 1, s_size out 2, s_wstrb out 4, s_addr out 32, s_wdata out 32, s_addr_ok in 1, s_data_ok in 1, s_rdata in 32; single shared SRAM-like memory port.
REQ-007 Port: err  out  1  sticky flag set on protocol violation.

Function
REQ-008 Handshakes: a request is accepted in the cycle where s_req and s_addr_ok are both 1; an answer is delivered in any cycle with s_data_ok=1; answers arrive in acceptance order.
REQ-009 Arbiter states: IDLE (no owner) and HOLD (owner registered, request presented but not yet accepted).
REQ-010 In IDLE, the owner is d if d_req=1, else i if i_req=1; data has fixed priority.
REQ-011 IDLE->HOLD when the chosen master's request is presented and is not accepted in that cycle; the owner is latched.
REQ-012 In HOLD, the latched owner's request is presented regardless of the other master; HOLD->IDLE on acceptance.
REQ-013 s_req = owner's req AND NOT full; s_wr/s_size/s_wstrb/s_addr/s_wdata = owner's fields (combinational mux); slave fields are 0 when there is no owner.
REQ-014 s_addr_ok is forwarded to the owner's *_addr_ok only while s_req=1; the non-owner's addr_ok is 0.
REQ-015 ID FIFO: DEPTH entries, 1 bit each (0=i, 1=d), with a count register of width clog2(DEPTH)+1; push on acceptance, pop on s_data_ok.
REQ-016 full = (count==DEPTH); while full, s_req=0 even if a pop occurs in the same cycle; new requests resume the following cycle.
REQ-017 Simultaneous push and pop when not full: count unchanged; head advances; the new entry is written at the tail.
REQ-018 Pointers wrap modulo DEPTH.
REQ-019 On s_data_ok with count>0: the head ID selects the destination; that master gets *_data_ok=1; the other master gets 0.
REQ-020 s_rdata is passed to both i_rdata and d_rdata unmodified, with zero latency.
REQ-021 s_data_ok with count==0 is ignored (no pop, no data_ok to either master) and sets err; err stays 1 until reset.
REQ-022 All arbiter-to-master and arbiter-to-slave paths are combinational; the only registered state is state, owner, FIFO, pointers, count, and err.

Reset
REQ-023 When resetn=0, asynchronously: state=IDLE, owner=i, count=0, pointers=0, err=0; therefore s_req=0, i_addr_ok=0, d_addr_ok=0, i_data_ok=0, d_data_ok=0.
REQ-024 Reset mid-transaction discards all outstanding IDs; s_data_ok responses after reset release go through REQ-021.

Structure
REQ-025 Shared package holds the ID encoding constants (ARB_ID_INST=0, ARB_ID_DATA=1) and the default DEPTH.
REQ-026 One sub-module, arb_id_fifo (parameterised depth/width, push/pop/full/empty/head), is instantiated once.

Verification
REQ-027 Both masters are idle and i_req=1 with addr 0x1C000000; the slave gives addr_ok the same cycle, then data_ok 2 cycles later with rdata 0xDEADBEEF -> i_addr_ok=1 once; i_data_ok=1 with i_rdata=0xDEADBEEF; d_data_ok=0 throughout.
REQ-028 i_req and d_req are asserted together, addr_ok=1 -> d is accepted first and i the next cycle; the FIFO holds {d,i}; two data_ok pulses go to d then i.
REQ-029 i_req=1 and the slave withholds addr_ok for 3 cycles while d_req rises in cycle 1 -> HOLD keeps i presented until accepted; d is accepted only afterwards.
REQ-030 DEPTH=4 with 4 accepted reads and no data_ok -> s_req=0 while a 5th request is pending; one data_ok -> the 5th request is presented one cycle later.
REQ-031 data_ok pulse with the FIFO empty -> neither master's data_ok is asserted, err=1 and stays 1; resetn=0 -> err=0.
REQ-032 resetn is asserted with 2 requests outstanding -> all outputs are 0 immediately and count=0 after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM-like two-master arbiter: ID encoding,
// default tracking depth, arbiter state type and the request field bundle.
package sram_arb_pkg;

    localparam int   ARB_DEPTH_DEFAULT = 4;
    localparam logic ARB_ID_INST       = 1'b0;
    localparam logic ARB_ID_DATA       = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    function automatic sram_req_t pack_req(
        input logic        wr,
        input logic [1:0]  size,
        input logic [3:0]  wstrb,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        sram_req_t r;
        r.wr    = wr;
        r.size  = size;
        r.wstrb = wstrb;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Small FIFO recording which master owns each accepted-but-unanswered request,
// so answers can be routed back in acceptance order.
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Overflow and underflow are refused here as a second line of defence.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/sram_arb.sv
// Arbiter merging the fetch (i_) and exe (d_) SRAM-like masters onto one slave
// port; data has fixed priority and answers are routed by a FIFO of owner IDs.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = ARB_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   resetn,

    input  logic                   i_req,
    input  logic                   i_wr,
    input  logic [1:0]             i_size,
    input  logic [3:0]             i_wstrb,
    input  logic [31:0]            i_addr,
    input  logic [31:0]            i_wdata,
    output logic                   i_addr_ok,
    output logic                   i_data_ok,
    output logic [31:0]            i_rdata,

    input  logic                   d_req,
    input  logic                   d_wr,
    input  logic [1:0]             d_size,
    input  logic [3:0]             d_wstrb,
    input  logic [31:0]            d_addr,
    input  logic [31:0]            d_wdata,
    output logic                   d_addr_ok,
    output logic                   d_data_ok,
    output logic [31:0]            d_rdata,

    output logic                   s_req,
    output logic                   s_wr,
    output logic [1:0]             s_size,
    output logic [3:0]             s_wstrb,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    input  logic                   s_addr_ok,
    input  logic                   s_data_ok,
    input  logic [31:0]            s_rdata,

    output logic                   err,
    output logic                   o_dbg_state,
    output logic [$clog2(DEPTH):0] o_dbg_count
);

    // Handshake: a request is accepted in a cycle with s_req & s_addr_ok, and
    // the master holds its fields until its addr_ok; an answer is any cycle
    // with s_data_ok, answers returning in acceptance order.

    arb_state_e r_state;
    arb_state_e w_next_state;
    logic       r_owner;
    logic       w_next_owner;
    logic       r_err;

    logic       w_owner;
    logic       w_owner_vld;
    logic       w_owner_req;
    logic       w_accept;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_head;
    sram_req_t  w_i_fields;
    sram_req_t  w_d_fields;
    sram_req_t  w_s_fields;

    assign w_i_fields = pack_req(i_wr, i_size, i_wstrb, i_addr, i_wdata);
    assign w_d_fields = pack_req(d_wr, d_size, d_wstrb, d_addr, d_wdata);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_owner <= ARB_ID_INST;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
        end
    end

    // Only a presented-but-refused request locks ownership.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (s_req && !s_addr_ok) begin
                    w_next_state = ST_HOLD;
                    w_next_owner = w_owner;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_owner     = r_owner;
        w_owner_vld = 1'b0;
        if (r_state == ST_HOLD) begin
            w_owner_vld = 1'b1;
        end else if (d_req) begin
            w_owner     = ARB_ID_DATA;
            w_owner_vld = 1'b1;
        end else if (i_req) begin
            w_owner     = ARB_ID_INST;
            w_owner_vld = 1'b1;
        end

        w_owner_req = (w_owner == ARB_ID_DATA) ? d_req : i_req;
        w_s_fields  = w_owner_vld ? ((w_owner == ARB_ID_DATA) ? w_d_fields : w_i_fields) : '0;

        // Full is judged at the start of the cycle; a same-cycle pop does not help.
        s_req       = w_owner_vld & w_owner_req & ~w_full;
        s_wr        = w_s_fields.wr;
        s_size      = w_s_fields.size;
        s_wstrb     = w_s_fields.wstrb;
        s_addr      = w_s_fields.addr;
        s_wdata     = w_s_fields.wdata;

        i_addr_ok   = s_req & s_addr_ok & (w_owner == ARB_ID_INST);
        d_addr_ok   = s_req & s_addr_ok & (w_owner == ARB_ID_DATA);
        i_data_ok   = w_pop & (w_head == ARB_ID_INST);
        d_data_ok   = w_pop & (w_head == ARB_ID_DATA);
    end

    assign w_accept = s_req & s_addr_ok;
    assign w_pop    = s_data_ok & ~w_empty;
    assign i_rdata  = s_rdata;
    assign d_rdata  = s_rdata;

    arb_id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (1)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_din   (w_owner),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (o_dbg_count)
    );

    // An answer with nothing outstanding is a slave protocol violation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (s_data_ok && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: directed scenarios plus a randomized run
// against a queue-based reference model of the arbiter.
module tb_sram_arb;
    import sram_arb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [3:0]  i_wstrb, d_wstrb;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        err;
    logic        o_dbg_state;
    logic [$clog2(DEPTH):0] o_dbg_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    sram_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
        .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err(err), .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
    );

    task automatic idle_inputs();
        i_req = 0; i_wr = 0; i_size = 2'd2; i_wstrb = 4'h0; i_addr = '0; i_wdata = '0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_wstrb = 4'h0; d_addr = '0; d_wdata = '0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        #3 resetn = 1'b0;
        #1;
        n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_sreq: got %h expected 0", s_req); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %h expected 0", err); end
        n_tests++; if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0) begin n_fail++; $display("FAIL rst_oks: got %b expected 0000", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}); end
        n_tests++; if (o_dbg_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", o_dbg_count); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        i_req = 1; i_addr = 32'h1C00_0000; s_addr_ok = 1;
        #1;
        n_tests++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL single_sreq: got %h expected 1", s_req); end
        n_tests++; if (s_addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL single_saddr: got %h expected 1c000000", s_addr); end
        n_tests++; if ({i_addr_ok, d_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL single_aok: got %b expected 10", {i_addr_ok, d_addr_ok}); end
        @(negedge clk);
        i_req = 0; s_addr_ok = 0;
        #1;
        n_tests++; if ({i_addr_ok, i_data_ok, d_data_ok} !== 3'b000) begin n_fail++; $display("FAIL single_quiet: got %b expected 000", {i_addr_ok, i_data_ok, d_data_ok}); end
        @(negedge clk);
        @(negedge clk);
        s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
        #1;
        n_tests++; if ({i_data_ok, d_data_ok} !== 2'b10) begin n_fail++; $display("FAIL single_dok: got %b expected 10", {i_data_ok, d_data_ok}); end
        n_tests++; if (i_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", i_rdata); end
        @(negedge clk);
        s_data_ok = 0;
        #1;
        n_tests++; if (o_dbg_count !== '0) begin n_fail++; $display("FAIL single_count: got %0d expected 0", o_dbg_count); end
        @(negedge clk);
    endtask

    task automatic test_priority();
        i_req = 1; i_addr = 32'h0000_1000; d_req = 1; d_addr = 32'h0000_2000; d_wr = 1; s_addr_ok = 1;
        #1;
        n_tests++; if (s_addr !== 32'h0000_2000 || s_wr !== 1'b1) begin n_fail++; $display("FAIL prio_first: got addr %h wr %h expected 00002000 1", s_addr, s_wr); end
        n_tests++; if ({i_addr_ok, d_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL prio_aok1: got %b expected 01", {i_addr_ok, d_addr_ok}); end
        @(negedge clk);
        d_req = 0; d_wr = 0;
        #1;
        n_tests++; if (s_addr !== 32'h0000_1000 || {i_addr_ok, d_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL prio_second: got addr %h aok %b expected 00001000 10", s_addr, {i_addr_ok, d_addr_ok}); end
        @(negedge clk);
        i_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h1111_2222;
        #1;
        n_tests++; if ({i_data_ok, d_data_ok} !== 2'b01) begin n_fail++; $display("FAIL prio_dok1: got %b expected 01", {i_data_ok, d_data_ok}); end
        n_tests++; if (d_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL prio_drdata: got %h expected 11112222", d_rdata); end
        @(negedge clk);
        s_rdata = 32'h3333_4444;
        #1;
        n_tests++; if ({i_data_ok, d_data_ok} !== 2'b10) begin n_fail++; $display("FAIL prio_dok2: got %b expected 10", {i_data_ok, d_data_ok}); end
        @(negedge clk);
        s_data_ok = 0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        i_req = 1; i_addr = 32'h0000_A000; s_addr_ok = 0;
        #1;
        n_tests++; if (s_req !== 1'b1 || i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL hold_c0: got sreq %h aok %h expected 1 0", s_req, i_addr_ok); end
        @(negedge clk);
        d_req = 1; d_addr = 32'h0000_B000;
        for (int c = 1; c < 3; c++) begin
            #1;
            n_tests++; if (s_addr !== 32'h0000_A000) begin n_fail++; $display("FAIL hold_keep: got %h expected 0000a000", s_addr); end
            n_tests++; if (o_dbg_state !== ST_HOLD) begin n_fail++; $display("FAIL hold_state: got %h expected 1", o_dbg_state); end
            @(negedge clk);
        end
        s_addr_ok = 1;
        #1;
        n_tests++; if ({i_addr_ok, d_addr_ok} !== 2'b10 || s_addr !== 32'h0000_A000) begin n_fail++; $display("FAIL hold_accept: got aok %b addr %h expected 10 0000a000", {i_addr_ok, d_addr_ok}, s_addr); end
        @(negedge clk);
        i_req = 0;
        #1;
        n_tests++; if ({i_addr_ok, d_addr_ok} !== 2'b01 || s_addr !== 32'h0000_B000) begin n_fail++; $display("FAIL hold_then_d: got aok %b addr %h expected 01 0000b000", {i_addr_ok, d_addr_ok}, s_addr); end
        @(negedge clk);
        d_req = 0; s_addr_ok = 0; s_data_ok = 1;
        #1;
        n_tests++; if ({i_data_ok, d_data_ok} !== 2'b10) begin n_fail++; $display("FAIL hold_dok1: got %b expected 10", {i_data_ok, d_data_ok}); end
        @(negedge clk);
        #1;
        n_tests++; if ({i_data_ok, d_data_ok} !== 2'b01) begin n_fail++; $display("FAIL hold_dok2: got %b expected 01", {i_data_ok, d_data_ok}); end
        @(negedge clk);
        s_data_ok = 0;
        @(negedge clk);
    endtask

    task automatic test_full();
        for (int k = 0; k < DEPTH; k++) begin
            i_req = 1; i_addr = 32'(k * 4); s_addr_ok = 1;
            #1;
            n_tests++; if (i_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: got %h expected 1", k, i_addr_ok); end
            @(negedge clk);
        end
        i_addr = 32'h0000_0FF0;
        #1;
        n_tests++; if (s_req !== 1'b0 || i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL full_block: got sreq %h aok %h expected 0 0", s_req, i_addr_ok); end
        n_tests++; if (o_dbg_count !== 3'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", o_dbg_count, DEPTH); end
        @(negedge clk);
        s_data_ok = 1;
        #1;
        n_tests++; if (s_req !== 1'b0 || i_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_popcycle: got sreq %h dok %h expected 0 1", s_req, i_data_ok); end
        @(negedge clk);
        s_data_ok = 0;
        #1;
        n_tests++; if (s_req !== 1'b1 || i_addr_ok !== 1'b1 || s_addr !== 32'h0000_0FF0) begin n_fail++; $display("FAIL full_resume: got sreq %h aok %h addr %h expected 1 1 00000ff0", s_req, i_addr_ok, s_addr); end
        @(negedge clk);
        i_req = 0; s_addr_ok = 0; s_data_ok = 1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            n_tests++; if (i_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_drain%0d: got %h expected 1", k, i_data_ok); end
            @(negedge clk);
        end
        s_data_ok = 0;
        #1;
        n_tests++; if (o_dbg_count !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL full_end: got count %0d err %h expected 0 0", o_dbg_count, err); end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        s_data_ok = 1; s_rdata = 32'h5555_AAAA;
        #1;
        n_tests++; if ({i_data_ok, d_data_ok} !== 2'b00) begin n_fail++; $display("FAIL spur_dok: got %b expected 00", {i_data_ok, d_data_ok}); end
        @(negedge clk);
        s_data_ok = 0;
        #1;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err: got %h expected 1", err); end
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %h expected 1", err); end
        resetn = 1'b0;
        #1;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL spur_clear: got %h expected 0", err); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_addr = 32'h0000_C000; s_addr_ok = 1;
        @(negedge clk);
        d_req = 0; i_req = 1; i_addr = 32'h0000_D000;
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (o_dbg_count !== 3'd2) begin n_fail++; $display("FAIL mid_pre: got %0d expected 2", o_dbg_count); end
        resetn = 1'b0;
        #1;
        n_tests++; if ({s_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, err} !== 6'b0 || s_addr !== '0) begin n_fail++; $display("FAIL mid_outs: got %b addr %h expected 000000 0", {s_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, err}, s_addr); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (o_dbg_count !== '0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", o_dbg_count); end
        @(negedge clk);
        s_data_ok = 1;
        #1;
        n_tests++; if ({i_data_ok, d_data_ok} !== 2'b00) begin n_fail++; $display("FAIL mid_stale: got %b expected 00", {i_data_ok, d_data_ok}); end
        @(negedge clk);
        s_data_ok = 0;
        #1;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL mid_err: got %h expected 1", err); end
        do_reset();
    endtask

    task automatic test_random();
        int   lock;
        int   own;
        logic i_pend, d_pend;
        logic exp_sreq, exp_pop;
        logic [31:0] exp_addr;
        logic exp_wr;
        do_reset();
        exp_q.delete();
        lock = -1; i_pend = 0; d_pend = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr = $urandom; i_wr = 1'($urandom_range(0, 1));
                i_wdata = $urandom; i_wstrb = 4'($urandom_range(0, 15)); i_size = 2'($urandom_range(0, 2));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_addr = $urandom; d_wr = 1'($urandom_range(0, 1));
                d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15)); d_size = 2'($urandom_range(0, 2));
            end
            i_req = i_pend;
            d_req = d_pend;
            s_addr_ok = 1'($urandom_range(0, 1));
            s_data_ok = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            #1;
            if (lock >= 0) own = lock;
            else if (d_pend) own = 1;
            else if (i_pend) own = 0;
            else own = -1;
            exp_sreq = (own == 1 && d_pend || own == 0 && i_pend) && (exp_q.size() < DEPTH);
            exp_addr = (own == 1) ? d_addr : (own == 0) ? i_addr : 32'h0;
            exp_wr   = (own == 1) ? d_wr : (own == 0) ? i_wr : 1'b0;
            exp_pop  = s_data_ok && (exp_q.size() > 0);
            n_tests++; if (s_req !== exp_sreq) begin n_fail++; $display("FAIL rnd_sreq c%0d: got %h expected %h", cyc, s_req, exp_sreq); end
            n_tests++; if (s_addr !== exp_addr || s_wr !== exp_wr) begin n_fail++; $display("FAIL rnd_fields c%0d: got %h/%h expected %h/%h", cyc, s_addr, s_wr, exp_addr, exp_wr); end
            n_tests++; if (i_addr_ok !== (exp_sreq && s_addr_ok && own == 0) || d_addr_ok !== (exp_sreq && s_addr_ok && own == 1)) begin n_fail++; $display("FAIL rnd_aok c%0d: got %b%b own %0d", cyc, i_addr_ok, d_addr_ok, own); end
            n_tests++; if (i_data_ok !== (exp_pop && exp_q[0] == 1'b0) || d_data_ok !== (exp_pop && exp_q[0] == 1'b1)) begin n_fail++; $display("FAIL rnd_dok c%0d: got %b%b expected pop %h", cyc, i_data_ok, d_data_ok, exp_pop); end
            n_tests++; if (i_rdata !== s_rdata || d_rdata !== s_rdata || err !== 1'b0) begin n_fail++; $display("FAIL rnd_misc c%0d: got %h %h err %h expected %h err 0", cyc, i_rdata, d_rdata, err, s_rdata); end
            if (exp_pop) void'(exp_q.pop_front());
            if (exp_sreq && s_addr_ok) begin
                exp_q.push_back(1'(own));
                lock = -1;
                if (own == 1) d_pend = 0; else i_pend = 0;
            end else if (exp_sreq) begin
                lock = own;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_priority();
        test_hold();
        test_full();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
